// File: rtl/tron_fb_pkg.sv
// Shared frame-buffer constants, colour encoding and word packing for the Tron display path.
package tron_fb_pkg;

  localparam int H_WORDS_DEF = 320;
  localparam int V_LINES_DEF = 480;
  localparam int FB_ADDR_W   = 19;

  typedef enum logic [3:0] {
    BG     = 4'h0,
    BLUE   = 4'h1,
    RED    = 4'h2,
    BORDER = 4'h7
  } color_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fb_state_e;

  // Each 16-bit word holds two pixels in nibbles [3:0] and [11:8].
  function automatic logic [15:0] pack_word(input logic [3:0] color);
    return {4'h0, color, 4'h0, color};
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Full-screen clear sweep: linear word counter and fill data.
// Border painting on the outer words is added when FB_CLEAR_BORDER_EN is defined.
module fb_clear_engine
  import tron_fb_pkg::*;
#(
  parameter int         H_WORDS      = H_WORDS_DEF,
  parameter int         V_LINES      = V_LINES_DEF,
  parameter int         ADDR_W       = FB_ADDR_W,
  parameter logic [3:0] BG_COLOR     = BG,
  parameter logic [3:0] BORDER_COLOR = BORDER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       data,
  output logic              done
);

  localparam int TOTAL = H_WORDS * V_LINES;

  logic [ADDR_W-1:0] count_reg;
  logic              border;

  // The counter parks at TOTAL once the last word is written; that value is the done flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (restart) begin
      count_reg <= '0;
    end else if (step) begin
      count_reg <= count_reg + ADDR_W'(1);
    end
  end

`ifdef FB_CLEAR_BORDER_EN
  localparam int CW = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
  localparam int LW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  logic [CW-1:0] col_reg;
  logic [LW-1:0] line_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg  <= '0;
      line_reg <= '0;
    end else if (restart) begin
      col_reg  <= '0;
      line_reg <= '0;
    end else if (step) begin
      if (col_reg == CW'(H_WORDS - 1)) begin
        col_reg  <= '0;
        line_reg <= line_reg + LW'(1);
      end else begin
        col_reg <= col_reg + CW'(1);
      end
    end
  end

  assign border = (line_reg == '0) || (line_reg == LW'(V_LINES - 1)) ||
                  (col_reg == '0)  || (col_reg == CW'(H_WORDS - 1));
`else
  assign border = 1'b0;
`endif

  assign addr = count_reg;
  assign data = border ? pack_word(BORDER_COLOR) : pack_word(BG_COLOR);
  assign done = (count_reg == ADDR_W'(TOTAL));

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port owner: clear sweep first, then round-robin blue/red trail writes.
// Optional border painting during clear is enabled by defining FB_CLEAR_BORDER_EN.
module fb_write_arbiter
  import tron_fb_pkg::*;
#(
  parameter int         H_WORDS      = H_WORDS_DEF,
  parameter int         V_LINES      = V_LINES_DEF,
  parameter int         ADDR_W       = FB_ADDR_W,
  parameter logic [3:0] BG_COLOR     = BG,
  parameter logic [3:0] BORDER_COLOR = BORDER
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear_start,
  input  logic              blue_req,
  input  logic [9:0]        blue_x,
  input  logic [9:0]        blue_y,
  input  logic [3:0]        blue_color,
  output logic              blue_ack,
  input  logic              red_req,
  input  logic [9:0]        red_x,
  input  logic [9:0]        red_y,
  input  logic [3:0]        red_color,
  output logic              red_ack,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [15:0]       fb_data,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              oob_err
);

  fb_state_e         state_reg;
  logic              last_red_reg;

  logic [ADDR_W-1:0] sweep_addr;
  logic [15:0]       sweep_data;
  logic              sweep_done;
  logic              sweep_step;

  logic              blue_elig;
  logic              red_elig;
  logic              grant_blue;
  logic              grant_red;
  logic [9:0]        g_x;
  logic [9:0]        g_y;
  logic [3:0]        g_color;
  logic              in_range;
  logic [ADDR_W-1:0] g_addr;

  assign sweep_step = (state_reg == CLEAR) && !clear_start && !sweep_done;

  fb_clear_engine #(
    .H_WORDS      (H_WORDS),
    .V_LINES      (V_LINES),
    .ADDR_W       (ADDR_W),
    .BG_COLOR     (BG_COLOR),
    .BORDER_COLOR (BORDER_COLOR)
  ) u_clear (
    .clk     (Clk),
    .rst     (Reset),
    .restart (clear_start),
    .step    (sweep_step),
    .addr    (sweep_addr),
    .data    (sweep_data),
    .done    (sweep_done)
  );

  // A requester whose ack is showing is still retiring its req and must not be granted again.
  always_comb begin
    blue_elig  = blue_req && !blue_ack;
    red_elig   = red_req && !red_ack;
    grant_blue = blue_elig && (!red_elig || last_red_reg);
    grant_red  = red_elig && !grant_blue;
    g_x        = grant_blue ? blue_x : red_x;
    g_y        = grant_blue ? blue_y : red_y;
    g_color    = grant_blue ? blue_color : red_color;
    in_range   = (int'(g_x) < 2 * H_WORDS) && (int'(g_y) < V_LINES);
    g_addr     = ADDR_W'(g_x >> 1) + ADDR_W'(g_y) * ADDR_W'(H_WORDS);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= CLEAR;
      last_red_reg <= 1'b1;
      fb_we        <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
      blue_ack     <= 1'b0;
      red_ack      <= 1'b0;
      clear_busy   <= 1'b1;
      clear_done   <= 1'b0;
      oob_err      <= 1'b0;
    end else begin
      blue_ack   <= 1'b0;
      red_ack    <= 1'b0;
      clear_done <= 1'b0;
      oob_err    <= 1'b0;
      fb_we      <= 1'b0;
      if (clear_start) begin
        state_reg  <= CLEAR;
        clear_busy <= 1'b1;
      end else if (state_reg == CLEAR) begin
        if (sweep_done) begin
          state_reg  <= RUN;
          clear_busy <= 1'b0;
          clear_done <= 1'b1;
        end else begin
          fb_we   <= 1'b1;
          fb_addr <= sweep_addr;
          fb_data <= sweep_data;
        end
      end else if (grant_blue || grant_red) begin
        blue_ack     <= grant_blue;
        red_ack      <= grant_red;
        last_red_reg <= grant_red;
        // Out-of-range requests are still acked so the requester never stalls.
        if (in_range) begin
          fb_we   <= 1'b1;
          fb_addr <= g_addr;
          fb_data <= pack_word(g_color);
        end else begin
          oob_err <= 1'b1;
        end
      end
    end
  end

endmodule
